flag_wb_stage: RTL and testbench

FLAG_WB_STAGE -- requirements
Module: flag_wb_stage

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/skid_fifo2.sv | 68 ++++++
 rtl/flag_wb_stage.sv | 88 ++++++++
 tb/tb_flag_wb_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, branch condition and flag encodings for the CPU datapath
package cpu_pkg;

  localparam logic [1:0] CLASS_ALU = 2'b11;
  localparam logic [4:0] CLASS_BR  = 5'b10111;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b1000;

  localparam logic [2:0] COND_BE  = 3'b000;
  localparam logic [2:0] COND_BLT = 3'b001;
  localparam logic [2:0] COND_BLE = 3'b010;
  localparam logic [2:0] COND_BNE = 3'b011;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_e;

  function automatic logic op3_valid(input logic [3:0] op3);
    logic ok;
    case (op3)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP, OP_MOV: ok = 1'b1;
      default:                                               ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Conditions 100-111 are not branches at all, so they never resolve taken.
  function automatic logic br_resolve(input logic [2:0] cond, input logic [3:0] f);
    logic lt;
    logic taken;
    lt = f[FLAG_S] ^ f[FLAG_V];
    case (cond)
      COND_BE:  taken = f[FLAG_Z];
      COND_BLT: taken = lt;
      COND_BLE: taken = f[FLAG_Z] | lt;
      COND_BNE: taken = ~f[FLAG_Z];
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// rtl/skid_fifo2.sv - two-entry valid/ready buffer with registered-state-only in_ready
module skid_fifo2
  import cpu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  fifo_state_e  state_q, state_d;
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic         push, pop;

  // rst_n gating keeps the stage closed while reset is held; no dependence on out_ready.
  assign in_ready  = rst_n & (state_q != FIFO_FULL);
  assign out_valid = (state_q != FIFO_EMPTY);
  assign out_data  = mem_q[rd_ptr_q];

  always_comb begin
    push     = in_valid & in_ready;
    pop      = out_valid & out_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case (state_q)
      FIFO_EMPTY: if (push) state_d = FIFO_ONE;
      FIFO_ONE: begin
        if (push && !pop)      state_d = FIFO_FULL;
        else if (pop && !push) state_d = FIFO_EMPTY;
      end
      FIFO_FULL:  if (pop) state_d = FIFO_ONE;
      default:    state_d = FIFO_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FIFO_EMPTY;
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/flag_wb_stage.sv
// rtl/flag_wb_stage.sv - ALU write-back stage: decode, flag register, branch resolve, 2-entry buffer
module flag_wb_stage
  import cpu_pkg::*;
#(
  parameter int         WIDTH    = 16,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [3:0]       in_code,
  input  logic [15:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wb_en,
  output logic [2:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             br_valid,
  output logic             br_taken,
  output logic [3:0]       flags
);

  localparam int REC_W = WIDTH + 6;

  logic [3:0]       flags_q, flags_d;
  logic             is_alu, is_br, op_ok, accept;
  logic [3:0]       op3;
  logic [2:0]       rd;
  logic             rec_wb_en, rec_br_valid, rec_br_taken;
  logic [REC_W-1:0] in_rec, head_rec;
  logic             head_valid;
  logic             h_wb_en, h_br_valid, h_br_taken;
  logic [2:0]       h_wb_addr;
  logic [WIDTH-1:0] h_wb_data;
  logic             unused_instr_bits;

  assign unused_instr_bits = ^in_instr[3:0];

  always_comb begin
    is_alu       = (in_instr[15:14] == CLASS_ALU);
    is_br        = (in_instr[15:11] == CLASS_BR);
    op3          = in_instr[7:4];
    rd           = in_instr[10:8];
    op_ok        = op3_valid(op3);
    accept       = in_valid & in_ready;
    rec_wb_en    = is_alu & op_ok & (op3 != OP_CMP);
    rec_br_valid = is_br & (rd <= COND_BNE);
    // Branches resolve against flags_q, which already holds any update from the previous accept.
    rec_br_taken = rec_br_valid & br_resolve(rd, flags_q);
    in_rec       = {rec_wb_en, rd, rec_br_valid, rec_br_taken, in_x};
    flags_d      = flags_q;
    if (accept && is_alu && op_ok) begin
      flags_d = in_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= FLAG_RST;
    end else begin
      flags_q <= flags_d;
    end
  end

  skid_fifo2 #(.W(REC_W)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_rec),
    .out_valid (head_valid),
    .out_ready (out_ready),
    .out_data  (head_rec)
  );

  assign {h_wb_en, h_wb_addr, h_br_valid, h_br_taken, h_wb_data} = head_rec;

  assign out_valid = head_valid;
  assign wb_en     = head_valid & h_wb_en;
  assign wb_addr   = head_valid ? h_wb_addr : 3'd0;
  assign wb_data   = head_valid ? h_wb_data : '0;
  assign br_valid  = head_valid & h_br_valid;
  assign br_taken  = head_valid & h_br_taken;
  assign flags     = flags_q;

endmodule

// File: tb/tb_flag_wb_stage.sv
// tb/tb_flag_wb_stage.sv - directed vector bench for flag_wb_stage
module tb_flag_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [3:0]  in_code;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        br_valid;
  logic        br_taken;
  logic [3:0]  flags;

  int tests;
  int failed;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] x;
    logic [3:0]  code;
    logic        wb_en;
    logic [2:0]  addr;
    logic        br_v;
    logic        br_t;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[16];

  flag_wb_stage #(.WIDTH(16), .FLAG_RST(4'b0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_code   (in_code),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .br_valid  (br_valid),
    .br_taken  (br_taken),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] instr, input logic [15:0] x, input logic [3:0] code);
    in_valid = 1'b1;
    in_instr = instr;
    in_x     = x;
    in_code  = code;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_x = '0;
    in_code = '0;
    out_ready = 1'b1;

    //         instr     x         code  wb  addr br_v br_t flags
    vecs[0]  = '{16'hC300, 16'h0005, 4'h0, 1'b1, 3'd3, 1'b0, 1'b0, 4'h0};
    vecs[1]  = '{16'hC050, 16'h1234, 4'h4, 1'b0, 3'd0, 1'b0, 1'b0, 4'h4};
    vecs[2]  = '{16'hB800, 16'h0000, 4'hF, 1'b0, 3'd0, 1'b1, 1'b1, 4'h4};
    vecs[3]  = '{16'hBB00, 16'h0000, 4'h0, 1'b0, 3'd3, 1'b1, 1'b0, 4'h4};
    vecs[4]  = '{16'hC110, 16'hFFFF, 4'h9, 1'b1, 3'd1, 1'b0, 1'b0, 4'h9};
    vecs[5]  = '{16'hB900, 16'h0001, 4'h0, 1'b0, 3'd1, 1'b1, 1'b0, 4'h9};
    vecs[6]  = '{16'hBA00, 16'h0002, 4'h0, 1'b0, 3'd2, 1'b1, 1'b0, 4'h9};
    vecs[7]  = '{16'hC240, 16'h8000, 4'h8, 1'b1, 3'd2, 1'b0, 1'b0, 4'h8};
    vecs[8]  = '{16'hB900, 16'h0003, 4'h0, 1'b0, 3'd1, 1'b1, 1'b1, 4'h8};
    vecs[9]  = '{16'hBA00, 16'h0004, 4'h0, 1'b0, 3'd2, 1'b1, 1'b1, 4'h8};
    vecs[10] = '{16'hC2F0, 16'hAAAA, 4'h6, 1'b0, 3'd2, 1'b0, 1'b0, 4'h8};
    vecs[11] = '{16'hBC00, 16'h0005, 4'h0, 1'b0, 3'd4, 1'b0, 1'b0, 4'h8};
    vecs[12] = '{16'hC780, 16'h0042, 4'h0, 1'b1, 3'd7, 1'b0, 1'b0, 4'h0};
    vecs[13] = '{16'hBB00, 16'h0006, 4'h0, 1'b0, 3'd3, 1'b1, 1'b1, 4'h0};
    vecs[14] = '{16'h0000, 16'h0007, 4'hF, 1'b0, 3'd0, 1'b0, 1'b0, 4'h0};
    vecs[15] = '{16'hC360, 16'h0008, 4'hF, 1'b0, 3'd3, 1'b0, 1'b0, 4'h0};

    // reset values while held
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_br", {br_valid, br_taken}, 0);
    check("rst_wb_addr_data", {wb_addr, wb_data}, 0);
    check("rst_flags", flags, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // table: one accept per cycle with out_ready high, 1-cycle latency
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].instr, vecs[i].x, vecs[i].code);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check($sformatf("v%0d_out_valid", i), out_valid, 1);
      check($sformatf("v%0d_in_ready", i), in_ready, 1);
      check($sformatf("v%0d_wb_en", i), wb_en, vecs[i].wb_en);
      check($sformatf("v%0d_wb_addr", i), wb_addr, vecs[i].addr);
      check($sformatf("v%0d_wb_data", i), wb_data, vecs[i].x);
      check($sformatf("v%0d_br_valid", i), br_valid, vecs[i].br_v);
      check($sformatf("v%0d_br_taken", i), br_taken, vecs[i].br_t);
      check($sformatf("v%0d_flags", i), flags, vecs[i].flags);
    end
    @(posedge clk);
    #1;
    check("drain_out_valid", out_valid, 0);
    check("drain_outs_zero", {wb_en, br_valid, br_taken, wb_addr, wb_data}, 0);

    // backpressure: three back-to-back pushes with out_ready low
    @(negedge clk);
    out_ready = 1'b0;
    drive(16'hC100, 16'h0001, 4'h3);
    @(posedge clk);
    #1;
    check("bp_a_in_ready", in_ready, 1);
    check("bp_a_data", wb_data, 16'h0001);
    check("bp_a_flags", flags, 4'h3);
    @(negedge clk);
    drive(16'hC200, 16'h0002, 4'h5);
    @(posedge clk);
    #1;
    check("bp_full_in_ready", in_ready, 0);
    check("bp_full_head", {wb_en, wb_addr, wb_data}, {1'b1, 3'd1, 16'h0001});
    check("bp_flags_during_stall", flags, 4'h5);
    @(negedge clk);
    drive(16'hC300, 16'h0003, 4'hF);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("bp_held_in_ready", in_ready, 0);
      check("bp_held_head", {out_valid, wb_addr, wb_data}, {1'b1, 3'd1, 16'h0001});
      check("bp_held_flags", flags, 4'h5);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_b_head", {wb_addr, wb_data}, {3'd2, 16'h0002});
    check("bp_b_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    check("bp_c_head", {out_valid, wb_addr, wb_data}, {1'b1, 3'd3, 16'h0003});
    check("bp_c_flags", flags, 4'hF);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("bp_empty", {out_valid, wb_en}, 0);

    // reset mid-operation with the buffer full
    @(negedge clk);
    out_ready = 1'b0;
    drive(16'hC100, 16'h0011, 4'hA);
    @(posedge clk);
    @(negedge clk);
    drive(16'hC200, 16'h0022, 4'hF);
    @(posedge clk);
    #1;
    check("mr_full", {in_ready, out_valid}, 2'b01);
    check("mr_flags_before", flags, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_out_valid", out_valid, 0);
    check("mr_outs_zero", {wb_en, br_valid, br_taken, wb_addr, wb_data}, 0);
    check("mr_flags", flags, 4'h0);
    check("mr_in_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    check("mr_release_in_ready", in_ready, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("mr_no_stale", {out_valid, wb_en, wb_data}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
